wb_cmd_master: RTL

Single-master Wishbone classic initiator that drives the SoC peripheral bus: wb_m2s_* out, wb_s2m_dat/ack in.
- Accepts read/write commands on a valid/ready stream and buffers them in a small command FIFO.
- Issues one single-beat bus cycle per command and returns one response per command on a valid/ready stream.
- Guards every cycle with a timeout so an unmapped or hung slave cannot lock the master.

---
 rtl/wb_cmd_pkg.sv | 26 ++
 rtl/wb_cmd_fifo.sv | 56 +++++
 rtl/wb_cmd_master.sv | 131 +++++++++++++
 3 files changed

// File: rtl/wb_cmd_pkg.sv
// Shared types for the Wishbone command master.
//   cmd_t      : one buffered bus command (direction, address, data, lane select)
//   rsp_code_t : completion status returned with every response
//   state_t    : bus sequencer states
package wb_cmd_pkg;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_ERR     = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_code_t;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous FIFO with registered input-ready and no fall-through.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write side; ready is registered "not full" (low while in reset)
//   pop/rdata  : read side; rdata shows the head entry while not empty
//   full/empty : occupancy flags
module wb_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             ready,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_next;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    assign count_next = count + CW'(do_push) - CW'(do_pop);

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            ready <= (count_next != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Single-master Wishbone classic initiator driven by a command stream.
//   wb_clk, wb_rst_n      : bus clock, asynchronous active-low reset
//   cmd_*                 : command stream in (valid/ready, we, adr, dat, sel)
//   rsp_*                 : response stream out (valid/ready, dat, code)
//   wb_m2s_*              : registered bus outputs
//   wb_s2m_dat/ack/err    : bus inputs from the slave
//   busy                  : commands queued or a transfer/response outstanding
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int unsigned CMD_DEPTH   = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic [1:0]  rsp_code,
    output logic [31:0] wb_m2s_adr,
    output logic [31:0] wb_m2s_dat,
    output logic [3:0]  wb_m2s_sel,
    output logic        wb_m2s_we,
    output logic        wb_m2s_cyc,
    output logic        wb_m2s_stb,
    input  logic [31:0] wb_s2m_dat,
    input  logic        wb_s2m_ack,
    input  logic        wb_s2m_err,
    output logic        busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);

    state_t    state;
    rsp_code_t rsp_code_q;
    logic [TW-1:0] tmo_cnt;
    cmd_t      cmd_in, fifo_out;
    logic      fifo_empty, fifo_full, pop;

    assign cmd_in = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
    assign pop    = (state == IDLE) && !fifo_empty;
    assign busy   = !fifo_empty || (state != IDLE);
    assign rsp_code = rsp_code_q;

    wb_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (wb_clk),
        .rst_n (wb_rst_n),
        .push  (cmd_valid && cmd_ready),
        .wdata (cmd_in),
        .ready (cmd_ready),
        .pop   (pop),
        .rdata (fifo_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The registered ready must never advertise space while the buffer is full.
    assert property (@(posedge wb_clk) disable iff (!wb_rst_n) !(fifo_full && cmd_ready));

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            wb_m2s_adr <= '0;
            wb_m2s_dat <= '0;
            wb_m2s_sel <= '0;
            wb_m2s_we  <= 1'b0;
            wb_m2s_cyc <= 1'b0;
            wb_m2s_stb <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_code_q <= RSP_OK;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        wb_m2s_adr <= fifo_out.adr;
                        wb_m2s_dat <= fifo_out.dat;
                        wb_m2s_sel <= fifo_out.sel;
                        wb_m2s_we  <= fifo_out.we;
                        wb_m2s_cyc <= 1'b1;
                        wb_m2s_stb <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= BUS;
                    end
                end
                BUS: begin
                    if (wb_s2m_err || wb_s2m_ack || (tmo_cnt == TO_LAST)) begin
                        wb_m2s_cyc <= 1'b0;
                        wb_m2s_stb <= 1'b0;
                        wb_m2s_we  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                        // err outranks ack; timeout only when the slave is silent.
                        if (wb_s2m_err) begin
                            rsp_code_q <= RSP_ERR;
                            rsp_dat    <= '0;
                        end else if (wb_s2m_ack) begin
                            rsp_code_q <= RSP_OK;
                            rsp_dat    <= wb_m2s_we ? 32'h0 : wb_s2m_dat;
                        end else begin
                            rsp_code_q <= RSP_TIMEOUT;
                            rsp_dat    <= '0;
                        end
                    end else if (tmo_cnt != TO_MAX) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
